// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (default 640x480@60 Hz) with HS/VS, pixel coordinates and blanking.
// Sync and blank are decoded from next-state counters so they stay aligned with x/y.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic       CLK,
   input  logic       RST_N,
   output logic       HS,
   output logic       VS,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       blank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
         $error("vga_sync_gen: line/frame total exceeds 10-bit counter range");
      end
   endgenerate

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] x_nxt;
   logic [9:0] y_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       blank_nxt;

   always_comb begin
      x_nxt = x + 10'd1;
      y_nxt = y;
      if (x == H_LAST) begin
         x_nxt = 10'd0;
         y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
      end
      hs_nxt    = (x_nxt >= HS_START && x_nxt <= HS_END) ? HS_POL : ~HS_POL;
      vs_nxt    = (y_nxt >= VS_START && y_nxt <= VS_END) ? VS_POL : ~VS_POL;
      blank_nxt = (x_nxt >= H_VIS) || (y_nxt >= V_VIS);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         x     <= 10'd0;
         y     <= 10'd0;
         HS    <= ~HS_POL;
         VS    <= ~VS_POL;
         blank <= 1'b0;
      end else begin
         x     <= x_nxt;
         y     <= y_nxt;
         HS    <= hs_nxt;
         VS    <= vs_nxt;
         blank <= blank_nxt;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line timing, shrunken instance for frame timing.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_d, rst_s;
   logic       hs_d, vs_d, blank_d, hs_s, vs_s, blank_s;
   logic [9:0] x_d, y_d, x_s, y_s;

   vga_sync_gen dut_d (
      .CLK(clk), .RST_N(rst_d), .HS(hs_d), .VS(vs_d), .x(x_d), .y(y_d), .blank(blank_d)
   );

   // 25 x 19 raster: HS at x=18..21, VS at y=14..15, active 16 x 12
   vga_sync_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_s (
      .CLK(clk), .RST_N(rst_s), .HS(hs_s), .VS(vs_s), .x(x_s), .y(y_s), .blank(blank_s)
   );

   typedef struct {
      int    cyc;
      int    x;
      int    y;
      int    hs;
      int    vs;
      int    blank;
      string name;
   } exp_t;

   exp_t q_d[$];
   exp_t q_s[$];
   int   checks = 0;
   int   errors = 0;
   int   cnt_d, cnt_s;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   task automatic cmp(input exp_t e, input logic [9:0] xa, input logic [9:0] ya,
                      input logic hsa, input logic vsa, input logic ba);
      chk({e.name, "_x"}, 32'(xa), e.x);
      chk({e.name, "_y"}, 32'(ya), e.y);
      chk({e.name, "_hs"}, 32'(hsa), e.hs);
      chk({e.name, "_vs"}, 32'(vsa), e.vs);
      chk({e.name, "_blank"}, 32'(ba), e.blank);
   endtask

   task automatic push_d(input int c, input int xe, input int ye, input int h, input int v,
                         input int b, input string n);
      exp_t e;
      e = '{c, xe, ye, h, v, b, n};
      q_d.push_back(e);
   endtask

   task automatic push_s(input int c, input int xe, input int ye, input int h, input int v,
                         input int b, input string n);
      exp_t e;
      e = '{c, xe, ye, h, v, b, n};
      q_s.push_back(e);
   endtask

   // clocks since reset release, counted by the bench
   always @(posedge clk or negedge rst_d)
      if (!rst_d) cnt_d <= 0; else cnt_d <= cnt_d + 1;
   always @(posedge clk or negedge rst_s)
      if (!rst_s) cnt_s <= 0; else cnt_s <= cnt_s + 1;

   always @(negedge clk) begin : mon_d
      exp_t e;
      if (rst_d === 1'b1) begin
         while (q_d.size() > 0 && q_d[0].cyc <= cnt_d) begin
            e = q_d.pop_front();
            if (e.cyc < cnt_d) chk({e.name, "_missed"}, cnt_d, e.cyc);
            else cmp(e, x_d, y_d, hs_d, vs_d, blank_d);
         end
      end
   end

   always @(negedge clk) begin : mon_s
      exp_t e;
      if (rst_s === 1'b1) begin
         while (q_s.size() > 0 && q_s[0].cyc <= cnt_s) begin
            e = q_s.pop_front();
            if (e.cyc < cnt_s) chk({e.name, "_missed"}, cnt_s, e.cyc);
            else cmp(e, x_s, y_s, hs_s, vs_s, blank_s);
         end
      end
   end

   // edge timestamps for period / pulse-width measurements
   logic prev_hs_d = 1'b1, prev_vs_s = 1'b1;
   int   d_fall1 = -1, d_fall2 = -1, d_rise1 = -1;
   int   s_fall1 = -1, s_rise1 = -1, s_rise2 = -1;

   always @(negedge clk) begin
      prev_hs_d <= hs_d;
      prev_vs_s <= vs_s;
      if (rst_d === 1'b1 && prev_hs_d === 1'b1 && hs_d === 1'b0) begin
         if (d_fall1 < 0) d_fall1 <= cnt_d;
         else if (d_fall2 < 0) d_fall2 <= cnt_d;
      end
      if (rst_d === 1'b1 && prev_hs_d === 1'b0 && hs_d === 1'b1 && d_rise1 < 0)
         d_rise1 <= cnt_d;
      if (rst_s === 1'b1 && prev_vs_s === 1'b1 && vs_s === 1'b0 && s_fall1 < 0)
         s_fall1 <= cnt_s;
      if (rst_s === 1'b1 && prev_vs_s === 1'b0 && vs_s === 1'b1) begin
         if (s_rise1 < 0) s_rise1 <= cnt_s;
         else if (s_rise2 < 0) s_rise2 <= cnt_s;
      end
   end

   initial begin
      int n;
      rst_d = 1'b0;
      rst_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_x", 32'(x_d), 0);
      chk("rst_hold_y", 32'(y_d), 0);
      chk("rst_hold_hs", 32'(hs_d), 1);
      chk("rst_hold_vs", 32'(vs_d), 1);
      chk("rst_hold_blank", 32'(blank_d), 0);

      //      cyc   x    y  hs vs bl
      push_d(0,    0,   0, 1, 1, 0, "d_reset");
      push_d(5,    5,   0, 1, 1, 0, "d_after5");
      push_d(639,  639, 0, 1, 1, 0, "d_last_vis");
      push_d(640,  640, 0, 1, 1, 1, "d_blank_on");
      push_d(655,  655, 0, 1, 1, 1, "d_pre_hs");
      push_d(656,  656, 0, 0, 1, 1, "d_hs_start");
      push_d(751,  751, 0, 0, 1, 1, "d_hs_end");
      push_d(752,  752, 0, 1, 1, 1, "d_hs_off");
      push_d(799,  799, 0, 1, 1, 1, "d_line_end");
      push_d(800,  0,   1, 1, 1, 0, "d_line_wrap");
      push_d(1456, 656, 1, 0, 1, 1, "d_hs_line1");

      push_s(0,   0,  0,  1, 1, 0, "s_reset");
      push_s(15,  15, 0,  1, 1, 0, "s_last_vis");
      push_s(16,  16, 0,  1, 1, 1, "s_blank_on");
      push_s(17,  17, 0,  1, 1, 1, "s_pre_hs");
      push_s(18,  18, 0,  0, 1, 1, "s_hs_start");
      push_s(21,  21, 0,  0, 1, 1, "s_hs_end");
      push_s(22,  22, 0,  1, 1, 1, "s_hs_off");
      push_s(274, 24, 10, 1, 1, 1, "s_line10_end");
      push_s(275, 0,  11, 1, 1, 0, "s_line11");
      push_s(300, 0,  12, 1, 1, 1, "s_vblank_x0");
      push_s(349, 24, 13, 1, 1, 1, "s_pre_vs");
      push_s(350, 0,  14, 1, 0, 1, "s_vs_start");
      push_s(399, 24, 15, 1, 0, 1, "s_vs_end");
      push_s(400, 0,  16, 1, 1, 1, "s_vs_off");
      push_s(474, 24, 18, 1, 1, 1, "s_frame_end");
      push_s(475, 0,  0,  1, 1, 0, "s_frame_wrap");

      @(posedge clk);
      #2;
      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (1500) @(posedge clk);
      #1;
      chk("d_queue_drained", q_d.size(), 0);
      chk("s_queue_drained", q_s.size(), 0);
      chk("hs_low_width", d_rise1 - d_fall1, 96);
      chk("hs_period", d_fall2 - d_fall1, 800);
      chk("vs_low_width", s_rise1 - s_fall1, 50);
      chk("vs_period", s_rise2 - s_rise1, 475);

      n = 0;
      while (!(x_s == 10'd5 && y_s == 10'd8) && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("midframe_reached", 32'(n < 600), 1);
      #1;
      rst_s = 1'b0;
      #1;
      chk("midrst_x", 32'(x_s), 0);
      chk("midrst_y", 32'(y_s), 0);
      chk("midrst_hs", 32'(hs_s), 1);
      chk("midrst_vs", 32'(vs_s), 1);
      chk("midrst_blank", 32'(blank_s), 0);

      push_s(0, 0, 0, 1, 1, 0, "s_rerelease");
      push_s(3, 3, 0, 1, 1, 0, "s_after3");
      @(posedge clk);
      #2;
      rst_s = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("s_queue_drained2", q_s.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
